// File: rtl/fp_lut_pkg.sv
// Shared widths, FP32 constants and the reciprocal table entry generator for fp_lut_recip.
package fp_lut_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 8;

  localparam logic [DATA_W-1:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [DATA_W-1:0] FP_ONE     = 32'h3F80_0000;

  // FP32 value of 1/idx, rounded to nearest-even; idx 0 maps to +inf.
  function automatic logic [DATA_W-1:0] recip_entry(input logic [IDX_W-1:0] idx);
    logic [63:0] num;
    logic [63:0] quo;
    logic [63:0] rem;
    logic [63:0] den;
    int unsigned e;
    logic [7:0]  bexp;
    if (idx == 8'd0) return FP_POS_INF;
    if (idx == 8'd1) return FP_ONE;
    // e = ceil(log2(idx)), so 2^e / idx lies in [1, 2)
    e = 0;
    for (int k = 0; k < 8; k++) begin
      if ((32'd1 << k) < 32'(idx)) e = k + 1;
    end
    den = 64'(idx);
    num = 64'd1 << (23 + e);
    quo = num / den;
    rem = num % den;
    if (((rem << 1) > den) || (((rem << 1) == den) && quo[0])) quo = quo + 64'd1;
    // Rounding can carry out of the 24-bit significand
    if (quo == (64'd1 << 24)) begin
      quo = 64'd1 << 23;
      e   = e - 1;
    end
    bexp = 8'(127 - e);
    return {1'b0, bexp, quo[22:0]};
  endfunction

endpackage

// File: rtl/fp_lut_rom.sv
// Combinational 256-entry FP32 reciprocal table, elaborated from recip_entry().
module fp_lut_rom
  import fp_lut_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_tab
    localparam logic [DATA_W-1:0] Entry = recip_entry(8'(g));
    assign rom[g] = Entry;
  end

  // Table read
  always_comb begin
    data_o = rom[idx_i];
  end

endmodule

// File: rtl/fp_lut_recip.sv
// AXI4-Stream reciprocal unit: index in, FP32 1/index out, with full backpressure.
// Optional macro FP_LUT_PIPE2_EN adds a second register stage (latency 2).
module fp_lut_recip
  import fp_lut_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESETN,  // active-high asynchronous reset
  output logic              S_AXIS_TREADY,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              M_AXIS_TVALID,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY
);

  logic [DATA_W-1:0] rom_data;
  logic              s1_ready;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_last_q;

  // Only the low index bits select an entry
  logic unused_hi;
  assign unused_hi = ^S_AXIS_TDATA[DATA_W-1:IDX_W];

  fp_lut_rom u_rom (
    .idx_i  (S_AXIS_TDATA[IDX_W-1:0]),
    .data_o (rom_data)
  );

`ifdef FP_LUT_PIPE2_EN
  logic              s2_ready;
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_last_q;

  assign s2_ready = !s2_valid_q || M_AXIS_TREADY;
  assign s1_ready = !s1_valid_q || s2_ready;

  // Output stage: advance from stage 1 whenever the output slot is free or draining
  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s1_data_q;
        s2_last_q <= s1_last_q;
      end
    end
  end

  assign M_AXIS_TVALID = s2_valid_q;
  assign M_AXIS_TDATA  = s2_data_q;
  assign M_AXIS_TLAST  = s2_last_q;
`else
  assign s1_ready = !s1_valid_q || M_AXIS_TREADY;

  assign M_AXIS_TVALID = s1_valid_q;
  assign M_AXIS_TDATA  = s1_data_q;
  assign M_AXIS_TLAST  = s1_last_q;
`endif

  // Ready is forced low while reset is held, since valid bits alone would report ready
  assign S_AXIS_TREADY = !ARESETN && s1_ready;

  // Table-read stage: capture payload only on a real input beat so idle X never propagates
  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
    end else if (s1_ready) begin
      s1_valid_q <= S_AXIS_TVALID;
      if (S_AXIS_TVALID) begin
        s1_data_q <= rom_data;
        s1_last_q <= S_AXIS_TLAST;
      end
    end
  end

endmodule

// File: tb/tb_fp_lut_recip.sv
// Randomized bench for fp_lut_recip against a queue-based reference model.
module tb_fp_lut_recip;

`ifdef FP_LUT_PIPE2_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic        ACLK;
  logic        ARESETN;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;

  fp_lut_recip dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;

  always @(posedge ACLK) ecnt <= ecnt + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          acc;
  } beat_t;

  beat_t       q[$];
  logic [31:0] obs[$];

  // 1/i via double-precision arithmetic, then rounded to single with nearest-even
  function automatic logic [31:0] ref_recip(input int i);
    logic [63:0] b;
    logic [30:0] em;
    logic [28:0] low;
    int          e;
    if (i == 0) return 32'h7F80_0000;
    b   = $realtobits(1.0 / real'(i));
    e   = int'(b[62:52]) - 1023 + 127;
    em  = {8'(e), b[51:29]};
    low = b[28:0];
    if ((low > 29'h1000_0000) || ((low == 29'h1000_0000) && em[0])) em = em + 31'd1;
    return {1'b0, em};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs, then advance the model by this edge's handshakes
  task automatic do_cycle(input logic v, input logic [31:0] d, input logic l, input logic mr);
    logic  exp_ready;
    logic  exp_valid;
    beat_t nb;
    @(negedge ACLK);
    S_AXIS_TVALID = v;
    S_AXIS_TDATA  = v ? d : 32'hxxxx_xxxx;
    S_AXIS_TLAST  = v ? l : 1'bx;
    M_AXIS_TREADY = mr;
    #1;
    exp_ready = !ARESETN && ((q.size() < Lat) || mr);
    exp_valid = (q.size() > 0) && (ecnt >= q[0].acc + Lat - 1);
    chk("s_tready", {31'd0, S_AXIS_TREADY}, {31'd0, exp_ready});
    chk("m_tvalid", {31'd0, M_AXIS_TVALID}, {31'd0, exp_valid});
    if (exp_valid && M_AXIS_TVALID) begin
      chk("m_tdata", M_AXIS_TDATA, ref_recip(int'(q[0].data[7:0])));
      chk("m_tlast", {31'd0, M_AXIS_TLAST}, {31'd0, q[0].last});
    end
    if (exp_valid && mr) begin
      obs.push_back(M_AXIS_TDATA);
      void'(q.pop_front());
    end
    if (v && S_AXIS_TREADY) begin
      nb.data = d;
      nb.last = l;
      nb.acc  = ecnt + 1;
      q.push_back(nb);
    end
  endtask

  logic [31:0] lit [5];

  initial begin
    lit[0] = 32'h3F80_0000;
    lit[1] = 32'h3BA3_D70A;
    lit[2] = 32'h3C86_4B8A;
    lit[3] = 32'h7F80_0000;
    lit[4] = 32'h3F00_0000;

    // Pin the reference model itself
    chk("ref_1",   ref_recip(1),   32'h3F80_0000);
    chk("ref_200", ref_recip(200), 32'h3BA3_D70A);
    chk("ref_61",  ref_recip(61),  32'h3C86_4B8A);
    chk("ref_3",   ref_recip(3),   32'h3EAA_AAAB);

    ARESETN       = 1'b1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b1;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      #1;
      chk("rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
      chk("rst_tdata", M_AXIS_TDATA, 32'd0);
      chk("rst_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    end
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    chk("rel_tready", {31'd0, S_AXIS_TREADY}, 32'd1);
    chk("rel_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("rel_tdata", M_AXIS_TDATA, 32'd0);

    // Back-to-back beats, index 0 and upper-bit masking
    do_cycle(1'b1, 32'h0000_0001, 1'b0, 1'b1);
    do_cycle(1'b1, 32'h0000_00C8, 1'b0, 1'b1);
    do_cycle(1'b1, 32'h0000_003D, 1'b0, 1'b1);
    do_cycle(1'b1, 32'h1234_5600, 1'b0, 1'b1);
    do_cycle(1'b1, 32'hFFFF_FF02, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    if (obs.size() < 5) begin
      n_cmp++;
      n_bad++;
      $display("FAIL directed_count: got %0d outputs, expected 5", obs.size());
    end else begin
      for (int i = 0; i < 5; i++) chk("directed_lit", obs[i], lit[i]);
    end

    // Backpressure: three stalled cycles mid-stream
    do_cycle(1'b1, 32'd5, 1'b0, 1'b1);
    do_cycle(1'b1, 32'd6, 1'b0, 1'b0);
    do_cycle(1'b1, 32'd7, 1'b0, 1'b0);
    do_cycle(1'b1, 32'd8, 1'b0, 1'b0);
    do_cycle(1'b1, 32'd9, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // TLAST on the third beat only
    do_cycle(1'b1, 32'd10, 1'b0, 1'b1);
    do_cycle(1'b1, 32'd11, 1'b0, 1'b1);
    do_cycle(1'b1, 32'd12, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Reset while a beat is in flight
    do_cycle(1'b1, 32'd20, 1'b0, 1'b0);
    for (int i = 0; i < Lat; i++) do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    chk("pre_rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("midrst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("midrst_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    q.delete();
    @(negedge ACLK);
    ARESETN = 1'b0;
    do_cycle(1'b1, 32'd4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Random traffic with random backpressure
    for (int i = 0; i < 2000; i++) begin
      do_cycle(($urandom % 4) != 0, $urandom, 1'($urandom % 2), ($urandom % 3) != 0);
    end
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_lut_recip.md
# fp_lut_recip

AXI4-Stream reciprocal unit built on a 256-entry FP32 lookup table. Each input beat's low 8 bits select an entry, and the block emits the IEEE-754 single-precision value of 1/index on the master stream. It sits between an integer producer and floating-point consumers as a single-clock pipeline stage with full backpressure support.

## Interface
- No parameters. Widths are fixed: 32-bit data, 8-bit index.
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESETN  in  1  reset; asynchronous, active-high (asserted when 1).
- S_AXIS_TREADY  out  1  slave ready.
- S_AXIS_TDATA  in  32  input word; bits [7:0] are the index, bits [31:8] are ignored.
- S_AXIS_TLAST  in  1  end-of-packet marker, passed through with its beat.
- S_AXIS_TVALID  in  1  slave valid.
- M_AXIS_TVALID  out  1  master valid.
- M_AXIS_TDATA  out  32  FP32 result.
- M_AXIS_TLAST  out  1  TLAST of the corresponding input beat.
- M_AXIS_TREADY  in  1  downstream ready.

## Operation
- Input transfer: S_AXIS_TVALID && S_AXIS_TREADY. Output transfer: M_AXIS_TVALID && M_AXIS_TREADY.
- Table content:
  - Entry i (1..255) = 1.0/i in FP32, rounded to nearest-even.
  - Entry 0 = +inf (0x7F800000).
  - Entry 1 = 0x3F800000.
- Data and TLAST travel together. Beat order is preserved. No beat is dropped or duplicated.
- Inputs X or Z while S_AXIS_TVALID=0 must not affect any output.
- Reset values: M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, all internal valid bits 0.
- S_AXIS_TREADY is 0 while reset is asserted.

## Timing
- Default latency is 1 cycle. A beat accepted on edge N is presented on M_AXIS_* after edge N (visible in cycle N+1).
- S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY. This is combinational. No combinational path exists from S_AXIS_TVALID to M_AXIS_*.
- Full throughput: one beat per cycle while M_AXIS_TREADY=1.
- Stall: while M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_TDATA and M_AXIS_TLAST hold stable and S_AXIS_TREADY=0.
- Simultaneous output transfer and input transfer: the output register is reloaded with the new beat in the same edge, with no bubble.
- Output transfer with no input transfer: M_AXIS_TVALID falls to 0 after the edge.
- Reset mid-stream: the in-flight beat is discarded immediately (asynchronous). After release, the first accepted beat appears with normal latency.

## Configuration
- FP_LUT_PIPE2_EN defined:
  - A second register stage is inserted after the table read, giving latency 2 cycles.
  - Ready propagates backward stage by stage, each stage using ready_k = !valid_k || ready_(k+1).
  - Throughput stays at one beat per cycle, and the stall/hold rules apply to the output stage.
- FP_LUT_PIPE2_EN undefined: single stage, as described above.

## Structure
- Package fp_lut_pkg holds:
  - DATA_W=32, IDX_W=8.
  - FP_POS_INF=32'h7F800000, FP_ONE=32'h3F800000.
  - A constant function that computes the reciprocal table entry for an index. It may be used to elaborate the table; a precomputed case list is equally acceptable.
- Sub-module fp_lut_rom: a purely combinational 8-bit index to 32-bit FP32 table.
- The top level holds the handshake and pipeline registers.

## Test plan
- Reset: hold ARESETN=1 for 2 cycles, then release with M_AXIS_TREADY=1 -> M_AXIS_TVALID=0, M_AXIS_TDATA=0, S_AXIS_TREADY=1 after release.
- Back-to-back beats 0x00000001, 0x000000C8, 0x0000003D with TREADY=1 -> outputs 0x3F800000, 0x3BA3D70A, 0x3C864B8A, one per cycle, each after 1 cycle of latency (2 cycles with FP_LUT_PIPE2_EN).
- Index 0 and upper-bit masking: input 0x12345600 -> 0x7F800000; input 0xFFFFFF02 -> 0x3F000000.
- Backpressure: drop M_AXIS_TREADY for 3 cycles mid-stream -> held data stays stable, S_AXIS_TREADY=0 during the stall, and no loss or duplication after TREADY returns.
- TLAST: send 3 beats with TLAST set on beat 3 -> M_AXIS_TLAST=1 only on the output for beat 3.
- Reset mid-stream: assert ARESETN while M_AXIS_TVALID=1 -> M_AXIS_TVALID=0 immediately, and the next beat after release is processed normally.
